// File: rtl/softmax_max_ctrl.sv
// Row-maximum sequencer for the softmax pipeline: streams N-element beats through a
// pipelined max tree and folds the per-beat maxima into a single row maximum.

module max_tree #(
    parameter int N = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      valid_in,
    input  logic [N*16-1:0]   data_flat,
    output logic              valid_out,
    output logic [15:0]       max_out,
    output logic [N*16-1:0]   prop_flat
);
    localparam int L = $clog2(N);

    // Heap layout: node i reduces children 2i and 2i+1; indices >= N are the inputs.
    // Every internal node is one register, so each leaf-to-root path has exactly L stages.
    logic signed [15:0] node [1:N-1];
    logic [L-1:0]       vld_pipe;
    logic [N*16-1:0]    prop_pipe [L];
    logic               all_valid;

    assign all_valid = &valid_in;

    for (genvar i = 1; i < N; i++) begin : g_node
        if (2 * i >= N) begin : g_leaf
            logic signed [15:0] lhs;
            logic signed [15:0] rhs;
            assign lhs = data_flat[(2*i-N)*16 +: 16];
            assign rhs = data_flat[(2*i+1-N)*16 +: 16];
            always_ff @(posedge clk) begin
                if (rst) node[i] <= '0;
                else     node[i] <= (lhs > rhs) ? lhs : rhs;
            end
        end else begin : g_inner
            always_ff @(posedge clk) begin
                if (rst) node[i] <= '0;
                else     node[i] <= (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int k = 0; k < L; k++) prop_pipe[k] <= '0;
        end else begin
            vld_pipe     <= L'({vld_pipe, all_valid});
            prop_pipe[0] <= data_flat;
            for (int k = 1; k < L; k++) prop_pipe[k] <= prop_pipe[k-1];
        end
    end

    assign valid_out = vld_pipe[L-1];
    assign max_out   = node[1];
    assign prop_flat = prop_pipe[L-1];
endmodule

module softmax_max_ctrl #(
    parameter int N       = 64,
    parameter int BEATS_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BEATS_W-1:0] num_beats,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*16-1:0]    in_flat,
    output logic               busy,
    output logic               max_valid,
    output logic [15:0]        max_out,
    output logic [N*16-1:0]    prop_flat,
    output logic [1:0]         state_dbg
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic signed [15:0] MOST_NEG = 16'sh8000;

    // Handshake: a beat transfers in any cycle where in_valid && in_ready; in_ready is
    // high only in FEED and never depends on in_valid.

    logic [1:0]         state;
    logic [BEATS_W-1:0] nb_q;
    logic [BEATS_W-1:0] sent_cnt;
    logic [BEATS_W-1:0] ret_cnt;
    logic [BEATS_W-1:0] sent_nxt;
    logic [BEATS_W-1:0] ret_nxt;
    logic signed [15:0] acc;
    logic signed [15:0] acc_fold;
    logic [15:0]        max_q;
    logic               accept;
    logic               fold;
    logic               t_valid;
    logic signed [15:0] t_max;

    assign in_ready  = (state == S_FEED);
    assign busy      = (state == S_FEED) || (state == S_DRAIN);
    assign max_valid = (state == S_DONE);
    assign max_out   = max_q;
    assign state_dbg = state;

    assign accept   = in_valid && in_ready;
    assign fold     = t_valid && busy;
    assign sent_nxt = sent_cnt + BEATS_W'(1);
    assign ret_nxt  = ret_cnt + BEATS_W'(1);
    assign acc_fold = (t_max > acc) ? t_max : acc;

    max_tree #(.N(N)) u_tree (
        .clk       (clk),
        .rst       (rst),
        .valid_in  ({N{accept}}),
        .data_flat (in_flat),
        .valid_out (t_valid),
        .max_out   (t_max),
        .prop_flat (prop_flat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            nb_q     <= '0;
            sent_cnt <= '0;
            ret_cnt  <= '0;
            acc      <= MOST_NEG;
            max_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc <= MOST_NEG;
                        if (num_beats != '0) begin
                            nb_q     <= num_beats;
                            sent_cnt <= '0;
                            ret_cnt  <= '0;
                            state    <= S_FEED;
                        end else begin
                            max_q <= MOST_NEG;
                            state <= S_DONE;
                        end
                    end
                end
                S_FEED: begin
                    if (accept) begin
                        sent_cnt <= sent_nxt;
                        if (sent_nxt == nb_q) state <= S_DRAIN;
                    end
                end
                S_DRAIN: ;
                default: state <= S_IDLE;
            endcase

            // Folding runs alongside feeding; the final return can only land in DRAIN.
            if (fold) begin
                acc     <= acc_fold;
                ret_cnt <= ret_nxt;
                if (ret_nxt == nb_q) begin
                    max_q <= acc_fold;
                    state <= S_DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_softmax_max_ctrl.sv
// Randomized scoreboard bench for softmax_max_ctrl (N=8, tree latency 3).

module tb_softmax_max_ctrl;
    localparam int N  = 8;
    localparam int L  = 3;
    localparam int BW = 8;
    localparam int W  = N * 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW-1:0] num_beats;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_flat;
    logic          busy;
    logic          max_valid;
    logic [15:0]   max_out;
    logic [W-1:0]  prop_flat;
    logic [1:0]    state_dbg;

    softmax_max_ctrl #(.N(N), .BEATS_W(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_beats (num_beats),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_flat   (in_flat),
        .busy      (busy),
        .max_valid (max_valid),
        .max_out   (max_out),
        .prop_flat (prop_flat),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [W-1:0] prop_q[$];
    int          prop_cyc_q[$];
    logic [W-1:0] beats[$];
    logic [15:0] last_max = 16'h0000;
    int          pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic flush();
        exp_q.delete();
        exp_cyc_q.delete();
        prop_q.delete();
        prop_cyc_q.delete();
    endtask

    // Reference: the row maximum is the largest signed element over all beats.
    function automatic logic [15:0] model_max(input int nb);
        logic signed [15:0] m;
        logic signed [15:0] v;
        m = 16'sh8000;
        for (int b = 0; b < nb; b++)
            for (int e = 0; e < N; e++) begin
                v = $signed(beats[b][e*16 +: 16]);
                if (v > m) m = v;
            end
        return m;
    endfunction

    function automatic logic [W-1:0] make_beat(input logic signed [15:0] mx, input int pos);
        logic [W-1:0] b;
        logic [15:0]  v;
        for (int e = 0; e < N; e++) begin
            v = 16'($urandom);
            if (e == pos) v = mx;
            else if ($signed(v) >= mx) v = 16'h8000 | (v & 16'h00FF);
            b[e*16 +: 16] = v;
        end
        return b;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] b;
        for (int e = 0; e < N; e++) b[e*16 +: 16] = 16'($urandom);
        return b;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (max_valid) begin
                if (exp_q.size() == 0) begin
                    flag("max_valid_unexpected");
                end else begin
                    check("max_out", W'(max_out), W'(exp_q[0]));
                    check("max_valid_cycle", W'(cyc), W'(exp_cyc_q[0]));
                    last_max = exp_q[0];
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
            while (prop_cyc_q.size() > 0 && prop_cyc_q[0] <= cyc) begin
                if (prop_cyc_q[0] == cyc) check("prop_flat", prop_flat, prop_q[0]);
                else flag("prop_flat_missed");
                void'(prop_q.pop_front());
                void'(prop_cyc_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_beats = '0; in_flat = '0;
        flush();
        tick();
        @(negedge clk);
        check("rst_in_ready", W'(in_ready), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_max_valid", W'(max_valid), '0);
        check("rst_max_out", W'(max_out), '0);
        check("rst_prop_flat", prop_flat, '0);
        check("rst_state", W'(state_dbg), '0);
        tick();
        rst = 1'b0;
        last_max = 16'h0000;
    endtask

    // mode 0: back-to-back, 1: fixed bubble pattern, 2: random bubbles
    task automatic run_row(input int nb, input int mode, input bit start_in_drain);
        int c;
        int idx;
        int att;
        int w;
        // Offer a huge beat while idle: it must not be accepted or folded.
        in_valid = 1'b1;
        for (int e = 0; e < N; e++) in_flat[e*16 +: 16] = 16'h7FFF;
        start = 1'b1;
        num_beats = BW'(nb);
        @(negedge clk);
        c = cyc;
        check("idle_in_ready", W'(in_ready), '0);
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        if (nb == 0) begin
            exp_q.push_back(16'h8000);
            exp_cyc_q.push_back(c + 1);
        end else begin
            idx = 0;
            att = 0;
            while (idx < nb && att < 200) begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (pat[att % 7] != 0);
                    default: in_valid = ($urandom_range(0, 3) != 0);
                endcase
                in_flat = beats[idx];
                @(negedge clk);
                if (in_valid && in_ready) begin
                    prop_q.push_back(beats[idx]);
                    prop_cyc_q.push_back(cyc + L);
                    idx++;
                    if (idx == nb) begin
                        exp_q.push_back(model_max(nb));
                        exp_cyc_q.push_back(cyc + L + 1);
                    end
                end
                att++;
                tick();
            end
            in_valid = 1'b0;
            if (idx < nb) flag("feed_timeout");
            if (start_in_drain) begin
                start = 1'b1;
                num_beats = BW'(3);
            end
            @(negedge clk);
            check("drain_in_ready", W'(in_ready), '0);
            check("drain_busy", W'(busy), 1);
            tick();
            start = 1'b0;
        end
        w = 0;
        while (exp_q.size() > 0 && w < 100) begin
            tick();
            w++;
        end
        if (exp_q.size() > 0) begin
            flag("done_timeout");
            flush();
        end
        tick();
        tick();
        @(negedge clk);
        check("idle_busy", W'(busy), '0);
        check("idle_max_hold", W'(max_out), W'(last_max));
        tick();
    endtask

    task automatic reset_mid_row();
        int att;
        int idx;
        beats.delete();
        for (int b = 0; b < 4; b++) beats.push_back(make_beat(16'sh7F00, b));
        start = 1'b1;
        num_beats = BW'(4);
        tick();
        start = 1'b0;
        idx = 0;
        att = 0;
        while (idx < 2 && att < 20) begin
            in_valid = 1'b1;
            in_flat = beats[idx];
            @(negedge clk);
            if (in_ready) idx++;
            att++;
            tick();
        end
        in_valid = 1'b0;
        if (idx < 2) flag("abort_feed_timeout");
        tick();
        rst = 1'b1;
        flush();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", W'(in_ready), '0);
        check("abort_busy", W'(busy), '0);
        check("abort_max_valid", W'(max_valid), '0);
        check("abort_max_out", W'(max_out), '0);
        check("abort_prop_flat", prop_flat, '0);
        last_max = 16'h0000;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] b;
        int nb;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_beats = '0; in_flat = '0;
        do_reset();

        // Single beat with extreme values.
        b[0*16 +: 16] = 16'hFFFB; b[1*16 +: 16] = 16'h0003;
        b[2*16 +: 16] = 16'h7FFF; b[3*16 +: 16] = 16'h8000;
        b[4*16 +: 16] = 16'h0001; b[5*16 +: 16] = 16'h0002;
        b[6*16 +: 16] = 16'h0003; b[7*16 +: 16] = 16'h0004;
        beats.delete();
        beats.push_back(b);
        run_row(1, 0, 1'b0);

        // Four beats with maxima 0x0100, 0x0400, 0x0200, 0xFF00; start pulsed in DRAIN.
        beats.delete();
        beats.push_back(make_beat(16'sh0100, 3));
        beats.push_back(make_beat(16'sh0400, 6));
        beats.push_back(make_beat(16'sh0200, 0));
        beats.push_back(make_beat(-16'sh0100, 7));
        run_row(4, 0, 1'b1);
        check("row4_max_value", W'(last_max), W'(16'h0400));
        run_row(4, 1, 1'b0);
        check("row4_bubbles_value", W'(last_max), W'(16'h0400));

        // All-negative row.
        beats.delete();
        for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < N; e++) b[e*16 +: 16] = 16'h9000;
            if (k == 1) b[5*16 +: 16] = 16'hFFFF;
            beats.push_back(b);
        end
        run_row(2, 2, 1'b0);
        check("neg_row_value", W'(last_max), W'(16'hFFFF));

        // Empty row.
        run_row(0, 0, 1'b0);

        // Reset mid-row, then a fresh single-beat row.
        reset_mid_row();
        beats.delete();
        beats.push_back(make_beat(-16'sh0200, 2));
        run_row(1, 0, 1'b0);

        // Random rows.
        for (int r = 0; r < 14; r++) begin
            nb = (r % 7 == 6) ? 0 : $urandom_range(1, 6);
            beats.delete();
            for (int k = 0; k < nb; k++) beats.push_back(rand_beat());
            run_row(nb, 2, ($urandom_range(0, 1) == 1));
        end

        repeat (4) tick();
        if (exp_q.size() != 0) flag("leftover_expectations");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/softmax_max_ctrl.md
# softmax_max_ctrl

Sequencing controller that computes the global maximum of a softmax input row longer than one max-tree width. The row arrives as a stream of N-element beats (signed Q6.10, 16 bits per element). The block instantiates one `max_tree` of width N and feeds it one beat per cycle under a valid/ready handshake. It folds the per-beat tree results into a running maximum and reports the row maximum with a one-cycle done pulse. It sits between the row buffer and the exponent/subtract stage of the softmax pipeline.

## Interface
- N, 64, elements per beat; power of two, ≥ 2; tree latency L = log2(N)
- BEATS_W, 8, width of beat counters; max row = 2^BEATS_W − 1 beats
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a row; honoured only in IDLE
- num_beats  in  BEATS_W  beats in the row; sampled when start is honoured
- in_valid  in  1  beat present on in_flat
- in_ready  out  1  controller accepts a beat this cycle
- in_flat  in  N*16  beat; element i at [i*16 +: 16], signed Q6.10
- busy  out  1  high in FEED and DRAIN
- max_valid  out  1  one-cycle pulse: max_out holds the row maximum
- max_out  out  16  signed row maximum; held until the next start
- prop_flat  out  N*16  in_flat delayed L cycles (tree pass-through); aligned with tree results, not gated by valid

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE, start=1, num_beats≠0:
  - latch num_beats;
  - clear sent_cnt and ret_cnt;
  - set acc = 16'sh8000 (most negative);
  - go to FEED.
- IDLE, start=1, num_beats=0: go to DONE with acc = 16'sh8000.
- FEED: in_ready = 1.
  - A beat is accepted when in_valid & in_ready.
  - An accepted beat drives the tree valid_in high; otherwise valid_in is low (bubble).
  - sent_cnt increments per accepted beat.
  - When the beat that makes sent_cnt == num_beats is accepted, go to DRAIN.
- in_ready is 0 in every state other than FEED. Beats offered outside FEED are neither accepted nor forwarded.
- Each cycle the tree valid_out is high:
  - acc ← signed max(acc, tree_out);
  - ret_cnt increments.
- FEED/DRAIN → DONE in the cycle when the return that makes ret_cnt == num_beats is folded.
  - A final return while still in FEED is impossible, because L ≥ 1.
- DONE: max_valid = 1 and max_out = acc, then IDLE the next cycle.
- max_out is registered. It updates only on entry to DONE and holds its value in IDLE.
- start asserted in FEED, DRAIN or DONE is ignored; no queuing.
- Arithmetic:
  - comparisons are signed 16-bit;
  - no saturation and no width growth;
  - the result equals one of the input elements, or 16'sh8000 for an empty row.
- Tree valid is the AND of element valids. The controller always drives all element valids together from the accept strobe.

## Timing
- Reset values:
  - in_ready = 0, busy = 0, max_valid = 0, max_out = 0;
  - prop_flat = 0 and tree pipeline cleared;
  - state = IDLE, counters = 0, acc = 16'sh8000.
- start is honoured in cycle c → state is FEED, with in_ready = 1, in cycle c+1.
- A beat accepted in cycle a → its tree result is folded in cycle a+L.
- Last beat accepted in cycle a → max_valid = 1 in cycle a+L+1 → back in IDLE in cycle a+L+2. The earliest new start is honoured in cycle a+L+2.
- Back-to-back beats give a throughput of 1 beat/cycle. Bubbles delay completion 1:1.
- Empty row: start in cycle c → max_valid in cycle c+1.
- prop_flat in cycle a+L equals the in_flat accepted in cycle a.
- rst mid-row:
  - the next cycle is IDLE with all outputs at reset values;
  - in-flight tree results are discarded, because the tree is reset with the same rst;
  - no max_valid is produced for the aborted row.

## Test plan
- Reset, then N=8 (L=3), num_beats=1, one beat with elements {−5, 3, 0x7FFF, −0x8000, 1, 2, 3, 4} → max_valid exactly 3+1 cycles after accept, max_out = 16'h7FFF.
- N=8, num_beats=4, back-to-back beats whose per-beat maxima are 0x0100, 0x0400, 0x0200, 0xFF00 (negative) → in_ready drops after the 4th accept; max_out = 0x0400; max_valid exactly once, 4 cycles after the last accept.
- Same row with in_valid toggled 1,0,0,1,1,0,1 → identical max_out; completion delayed by the 3 bubbles; no beat counted twice.
- All-negative row, every element = −0x7000 except one element = −0x0001 → max_out = 16'hFFFF.
- num_beats=0 → max_valid in the cycle after start, max_out = 16'h8000. start pulsed during DRAIN of another row → ignored, that row's result unaffected.
- rst asserted 2 cycles after the 2nd of 4 beats → all outputs zero next cycle. A new num_beats=1 row afterwards returns only its own maximum, with no stale result from the aborted row.
